// File: rtl/game_flow_ctrl.sv
// Round/life sequencer for the maze game: sequences start, ready, play,
// death, respawn, game-over and win phases, drives lives_reg and issues
// restart / lifeDown strobes. Intervals are timed in video frames.
module game_flow_ctrl #(
   parameter logic [7:0] START_KEY      = 8'h2C,
   parameter logic [7:0] START_LIVES    = 8'd3,
   parameter logic [7:0] READY_FRAMES   = 8'd120,
   parameter logic [7:0] DEATH_FRAMES   = 8'd90,
   parameter logic [7:0] RESPAWN_FRAMES = 8'd60
) (
   input  logic       Clk,
   input  logic       Reset_n,
   input  logic       frame_clk,
   input  logic [7:0] keycode,
   input  logic       caught,
   input  logic       all_dots,
   input  logic [7:0] lives_from_reg,
   output logic       Load_L,
   output logic [7:0] lives_to_reg,
   output logic       restart,
   output logic       lifeDown,
   output logic       freeze,
   output logic       game_over,
   output logic       game_won,
   output logic [2:0] state
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_INIT    = 3'd1,
      S_READY   = 3'd2,
      S_PLAY    = 3'd3,
      S_DYING   = 3'd4,
      S_RESPAWN = 3'd5,
      S_OVER    = 3'd6,
      S_WON     = 3'd7
   } state_t;

   // A zero-length interval would never end; it is stretched to one frame.
   localparam logic [7:0] READY_N   = (READY_FRAMES   == 8'd0) ? 8'd1 : READY_FRAMES;
   localparam logic [7:0] DEATH_N   = (DEATH_FRAMES   == 8'd0) ? 8'd1 : DEATH_FRAMES;
   localparam logic [7:0] RESPAWN_N = (RESPAWN_FRAMES == 8'd0) ? 8'd1 : RESPAWN_FRAMES;

   state_t     r_state;
   state_t     w_next;
   logic       r_fs1;
   logic       r_fs2;
   logic       r_fs3;
   logic       r_match_d;
   logic [7:0] r_cnt;

   logic       w_tick;
   logic       w_match;
   logic       w_press;
   logic       w_ready_done;
   logic       w_death_done;
   logic       w_respawn_done;
   logic       w_load;
   logic       w_restart;
   logic       w_lifedown;
   logic [7:0] w_lives_data;

   assign w_tick         = r_fs2 & ~r_fs3;
   assign w_match        = (keycode == START_KEY);
   assign w_press        = w_match & ~r_match_d;
   assign w_ready_done   = w_tick && (r_cnt == READY_N   - 8'd1);
   assign w_death_done   = w_tick && (r_cnt == DEATH_N   - 8'd1);
   assign w_respawn_done = w_tick && (r_cnt == RESPAWN_N - 8'd1);

   // Synchronize vertical sync into Clk and keep one history stage for edge detect;
   // also remember whether the start key matched last cycle.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_fs1     <= 1'b0;
         r_fs2     <= 1'b0;
         r_fs3     <= 1'b0;
         r_match_d <= 1'b0;
      end else begin
         r_fs1     <= frame_clk;
         r_fs2     <= r_fs1;
         r_fs3     <= r_fs2;
         r_match_d <= w_match;
      end
   end

   // Next-state and strobe decode; strobes are decided on the transition and
   // registered, so they appear in the first cycle of the destination state.
   always_comb begin
      w_next       = r_state;
      w_load       = 1'b0;
      w_restart    = 1'b0;
      w_lifedown   = 1'b0;
      w_lives_data = lives_to_reg;
      case (r_state)
         S_IDLE, S_OVER, S_WON: begin
            if (w_press) begin
               w_next       = S_INIT;
               w_load       = 1'b1;
               w_restart    = 1'b1;
               w_lives_data = START_LIVES;
            end
         end
         S_INIT: w_next = S_READY;
         S_READY: begin
            if (w_ready_done) w_next = S_PLAY;
         end
         S_PLAY: begin
            if (all_dots)    w_next = S_WON;
            else if (caught) w_next = S_DYING;
         end
         S_DYING: begin
            if (w_death_done) begin
               if (lives_from_reg > 8'd1) begin
                  w_next       = S_RESPAWN;
                  w_load       = 1'b1;
                  w_lifedown   = 1'b1;
                  w_lives_data = lives_from_reg - 8'd1;
               end else if (lives_from_reg == 8'd1) begin
                  w_next       = S_OVER;
                  w_load       = 1'b1;
                  w_lives_data = 8'd0;
               end else begin
                  w_next = S_OVER;
               end
            end
         end
         S_RESPAWN: begin
            if (w_respawn_done) w_next = S_PLAY;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // State register, frame counter (cleared on any state change) and strobe registers.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_state      <= S_IDLE;
         r_cnt        <= '0;
         Load_L       <= 1'b0;
         restart      <= 1'b0;
         lifeDown     <= 1'b0;
         lives_to_reg <= '0;
      end else begin
         r_state      <= w_next;
         Load_L       <= w_load;
         restart      <= w_restart;
         lifeDown     <= w_lifedown;
         lives_to_reg <= w_lives_data;
         if (w_next != r_state) r_cnt <= '0;
         else if (w_tick)       r_cnt <= r_cnt + 8'd1;
      end
   end

   assign freeze    = (r_state != S_PLAY);
   assign game_over = (r_state == S_OVER);
   assign game_won  = (r_state == S_WON);
   assign state     = r_state;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Randomized bench for game_flow_ctrl: an action-level game model predicts
// strobe events into a scoreboard and the phase after every action.
module tb_game_flow_ctrl;

   localparam int unsigned RDY_N = 2;
   localparam int unsigned DTH_N = 3;
   localparam int unsigned RSP_N = 2;
   localparam logic [7:0]  LIVES0 = 8'd3;

   localparam logic [2:0] P_IDLE = 3'd0, P_INIT = 3'd1, P_READY = 3'd2, P_PLAY = 3'd3,
                          P_DYING = 3'd4, P_RESPAWN = 3'd5, P_OVER = 3'd6, P_WON = 3'd7;

   typedef struct packed {
      logic       load;
      logic       rst;
      logic       ld;
      logic [7:0] data;
      logic [2:0] st;
   } pulse_t;

   logic       Clk = 1'b0;
   logic       Reset_n = 1'b0;
   logic       frame_clk = 1'b0;
   logic [7:0] keycode = 8'h00;
   logic       caught = 1'b0;
   logic       all_dots = 1'b0;
   logic [7:0] lives_from_reg;
   logic       Load_L;
   logic [7:0] lives_to_reg;
   logic       restart;
   logic       lifeDown;
   logic       freeze;
   logic       game_over;
   logic       game_won;
   logic [2:0] state;

   int checks = 0;
   int errors = 0;

   pulse_t sb[$];

   // environment: the external lives register plus an optional override
   logic [7:0] env_lives;
   logic       use_ovr = 1'b0;
   logic [7:0] ovr_val = 8'd0;
   assign lives_from_reg = use_ovr ? ovr_val : env_lives;

   // reference model state
   logic [2:0]  m_state = P_IDLE;
   int unsigned m_cnt = 0;

   game_flow_ctrl #(
      .START_KEY(8'h2C),
      .START_LIVES(LIVES0),
      .READY_FRAMES(8'd2),
      .DEATH_FRAMES(8'd3),
      .RESPAWN_FRAMES(8'd2)
   ) dut (
      .Clk(Clk),
      .Reset_n(Reset_n),
      .frame_clk(frame_clk),
      .keycode(keycode),
      .caught(caught),
      .all_dots(all_dots),
      .lives_from_reg(lives_from_reg),
      .Load_L(Load_L),
      .lives_to_reg(lives_to_reg),
      .restart(restart),
      .lifeDown(lifeDown),
      .freeze(freeze),
      .game_over(game_over),
      .game_won(game_won),
      .state(state)
   );

   always #10 Clk = ~Clk;

   always @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n)    env_lives <= 8'd0;
      else if (Load_L) env_lives <= lives_to_reg;
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
      end
   endtask

   task automatic cyc(input int unsigned n);
      repeat (n) @(negedge Clk);
   endtask

   task automatic chk_phase(input string name);
      chk(name, 32'({state, freeze, game_over, game_won}),
          32'({m_state, m_state != P_PLAY, m_state == P_OVER, m_state == P_WON}));
   endtask

   task automatic push(input logic ld_l, input logic rs, input logic ld, input logic [7:0] d,
                       input logic [2:0] st);
      pulse_t p;
      p.load = ld_l; p.rst = rs; p.ld = ld; p.data = d; p.st = st;
      sb.push_back(p);
   endtask

   function automatic logic [7:0] rand_noise_key();
      logic [7:0] k;
      k = 8'($urandom_range(0, 255));
      if (k == 8'h2C) k = 8'h00;
      return k;
   endfunction

   task automatic do_press(input int unsigned hold);
      if (m_state == P_IDLE || m_state == P_OVER || m_state == P_WON) begin
         push(1'b1, 1'b1, 1'b0, LIVES0, P_INIT);
         m_state = P_READY;
         m_cnt   = 0;
         use_ovr = 1'b0;
      end
      keycode = 8'h2C;
      cyc(hold);
      keycode = rand_noise_key();
      cyc(2);
      chk_phase("press");
   endtask

   task automatic do_tick();
      logic [7:0] l;
      logic       resolved;
      resolved = 1'b0;
      m_cnt++;
      if (m_state == P_READY && m_cnt == RDY_N) begin
         m_state = P_PLAY; m_cnt = 0;
      end else if (m_state == P_RESPAWN && m_cnt == RSP_N) begin
         m_state = P_PLAY; m_cnt = 0;
      end else if (m_state == P_DYING && m_cnt == DTH_N) begin
         l = use_ovr ? ovr_val : env_lives;
         resolved = 1'b1;
         m_cnt = 0;
         if (l > 8'd1) begin
            push(1'b1, 1'b0, 1'b1, l - 8'd1, P_RESPAWN);
            m_state = P_RESPAWN;
         end else if (l == 8'd1) begin
            push(1'b1, 1'b0, 1'b0, 8'd0, P_OVER);
            m_state = P_OVER;
         end else begin
            m_state = P_OVER;
         end
      end
      frame_clk = 1'b1;
      cyc(4);
      frame_clk = 1'b0;
      cyc(4);
      if (resolved) use_ovr = 1'b0;
      chk_phase("tick");
   endtask

   task automatic do_evt(input logic c, input logic a);
      if (m_state == P_PLAY) begin
         if (a) begin
            m_state = P_WON; m_cnt = 0;
         end else if (c) begin
            m_state = P_DYING; m_cnt = 0;
         end
      end
      caught   = c;
      all_dots = a;
      cyc(1);
      caught   = 1'b0;
      all_dots = 1'b0;
      cyc(2);
      chk_phase("event");
   endtask

   // Monitor: every strobe cycle must match the oldest predicted event.
   initial begin : monitor
      logic   prev;
      logic   cur;
      pulse_t exp;
      prev = 1'b0;
      forever begin
         @(negedge Clk);
         if (!Reset_n) begin
            prev = 1'b0;
         end else begin
            cur = Load_L | restart | lifeDown;
            if (cur) begin
               chk("pulse_spacing", 32'(prev), 32'(1'b0));
               if (sb.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_pulse: got load=%b restart=%b lifeDown=%b data=%0d state=%0d expected none",
                           Load_L, restart, lifeDown, lives_to_reg, state);
               end else begin
                  exp = sb.pop_front();
                  chk("pulse", 32'({Load_L, restart, lifeDown, lives_to_reg, state}), 32'(exp));
               end
            end
            prev = cur;
         end
      end
   end

   initial begin : watchdog
      #5_000_000;
      errors++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $fatal(1, "timeout");
   end

   initial begin : stimulus
      int unsigned sel;
      cyc(3);
      chk("reset", 32'({Load_L, lives_to_reg, restart, lifeDown, freeze, game_over, game_won, state}),
          32'({1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0}));
      Reset_n = 1'b1;
      cyc(2);
      chk_phase("idle");

      // start with key held 10 cycles, then ready interval
      do_press(10);
      do_tick();
      do_tick();
      // death with 3 lives -> respawn -> play
      do_evt(1'b1, 1'b0);
      repeat (DTH_N) do_tick();
      repeat (RSP_N) do_tick();
      // last life lost -> over, then restart
      use_ovr = 1'b1; ovr_val = 8'd1;
      do_evt(1'b1, 1'b0);
      repeat (DTH_N) do_tick();
      do_press(1);
      do_tick();
      do_tick();
      // caught and all_dots together -> won
      do_evt(1'b1, 1'b1);
      do_press(3);
      do_tick();
      do_tick();
      // ignored inputs: press in play, caught in dying and respawn
      do_press(2);
      do_evt(1'b1, 1'b0);
      do_evt(1'b1, 1'b0);
      do_press(1);
      repeat (DTH_N) do_tick();
      do_evt(1'b1, 1'b0);
      repeat (RSP_N) do_tick();
      // reset in the middle of dying
      do_evt(1'b1, 1'b0);
      do_tick();
      do_tick();
      Reset_n = 1'b0;
      cyc(3);
      Reset_n = 1'b1;
      m_state = P_IDLE; m_cnt = 0; use_ovr = 1'b0;
      cyc(1);
      chk_phase("mid_reset");
      repeat (4) do_tick();

      // randomized play
      for (int i = 0; i < 300; i++) begin
         sel = $urandom_range(0, 99);
         if (sel < 45) begin
            do_tick();
         end else if (sel < 60) begin
            do_press($urandom_range(1, 4));
         end else if (sel < 87) begin
            if (m_state == P_PLAY && $urandom_range(0, 2) == 0) begin
               use_ovr = 1'b1;
               ovr_val = 8'($urandom_range(0, 4));
            end
            if (sel < 75)      do_evt(1'b1, 1'b0);
            else if (sel < 82) do_evt(1'b0, 1'b1);
            else               do_evt(1'b1, 1'b1);
         end else if (sel < 95) begin
            keycode = rand_noise_key();
            cyc($urandom_range(1, 3));
            chk_phase("noise_key");
         end else begin
            cyc($urandom_range(1, 5));
            chk_phase("idle_gap");
         end
      end

      cyc(5);
      chk("scoreboard_drain", 32'(sb.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/game_flow_ctrl.md
Name: game_flow_ctrl

Overview:
- Round/life sequencer for the maze game.
- Owns lives_reg (drives its Load/Data_in) and issues the restart and lifeDown strobes consumed by the player, ghost and game-logic blocks.
- Drives a freeze level that halts movement during ready, death and respawn intervals.
- Times every interval in video frames, counting frame_clk (VGA_VS) edges inside the 50 MHz Clk domain.

Parameters:
- START_KEY, 8'h2C: keycode that starts or restarts a game (space).
- START_LIVES, 8'd3: lives loaded at game start.
- READY_FRAMES, 8'd120: frozen frames before play begins.
- DEATH_FRAMES, 8'd90: frames the death animation is held.
- RESPAWN_FRAMES, 8'd60: frozen frames after respawn, before play resumes.

Ports:
- Clk  in  1  system clock (MAX10_CLK1_50).
- Reset_n  in  1  asynchronous, active-low reset.
- frame_clk  in  1  VGA vertical sync, asynchronous to Clk.
- keycode  in  8  current USB keycode.
- caught  in  1  level; player overlaps a non-frightened ghost.
- all_dots  in  1  level; dots_left == 0.
- lives_from_reg  in  8  current lives.
- Load_L  out  1  lives_reg load strobe.
- lives_to_reg  out  8  lives_reg data.
- restart  out  1  one-Clk pulse; reset the board, positions and score.
- lifeDown  out  1  one-Clk pulse; return actors to spawn.
- freeze  out  1  level; movement disabled.
- game_over  out  1  level; high in OVER.
- game_won  out  1  level; high in WON.
- state  out  3  encoded state, for HEX/debug display.

Behaviour:
- Reset (async, Reset_n=0):
  - state=IDLE, frame counter=0, sync flops=0, key-match history=0.
  - Load_L=0, lives_to_reg=0, restart=0, lifeDown=0, freeze=1, game_over=0, game_won=0.
- Frame tick:
  - frame_clk passes through a 2-flop synchronizer plus one history flop.
  - tick = 1 for exactly one Clk on each rising edge of the synchronized signal.
  - Latency: 2–3 Clk after the VS rising edge.
- Start press:
  - press = (keycode==START_KEY) && !match_d, where match_d registers the previous match.
  - Holding the key produces one press only.
- Frame counter: 8-bit; cleared on every state change; increments on tick only; an interval ends on the tick where counter == N-1.
- State encoding: IDLE=0, INIT=1, READY=2, PLAY=3, DYING=4, RESPAWN=5, OVER=6, WON=7.
- IDLE: freeze=1. press → INIT.
- INIT (exactly 1 Clk):
  - Load_L=1, lives_to_reg=START_LIVES, restart=1 in this cycle.
  - → READY.
- READY: freeze=1. After READY_FRAMES ticks → PLAY.
- PLAY: freeze=0.
  - all_dots → WON; all_dots has priority over a simultaneous caught.
  - else caught → DYING.
  - press is ignored.
- DYING: freeze=1; caught and all_dots are ignored. After DEATH_FRAMES ticks, in the transition cycle:
  - If lives_from_reg > 1: Load_L=1, lives_to_reg=lives_from_reg-1, lifeDown=1 → RESPAWN.
  - If lives_from_reg == 1: Load_L=1, lives_to_reg=0 → OVER, with no lifeDown.
  - If lives_from_reg == 0 (saturation guard): no load → OVER.
- RESPAWN: freeze=1. After RESPAWN_FRAMES ticks → PLAY.
- OVER: freeze=1, game_over=1. press → INIT.
- WON: freeze=1, game_won=1. press → INIT.
- Output timing:
  - Load_L, restart and lifeDown are registered and high for exactly one Clk.
  - They are never asserted in consecutive cycles.
- Interval parameter of 0: treated as 1.
- Reset mid-operation: returns to IDLE immediately; pending pulses are dropped; lives_reg itself is reset by its own reset.
- A tick and a press in the same cycle are independent; state-specific rules apply.

Test Plan (READY_FRAMES=2, DEATH_FRAMES=3, RESPAWN_FRAMES=2, START_LIVES=3):
- Reset, then keycode=8'h2C held for 10 Clk → exactly one INIT cycle (Load_L=1, lives_to_reg=3, restart=1); state=READY; state=PLAY and freeze=0 after the 2nd frame tick.
- In PLAY, pulse caught with lives=3 → DYING, freeze=1; on the 3rd tick Load_L=1, lives_to_reg=2, lifeDown=1; RESPAWN; PLAY after 2 ticks.
- In PLAY with lives_from_reg=1, caught → after 3 ticks lives_to_reg=0, no lifeDown, state=OVER, game_over=1; then press → INIT and lives reload to 3.
- caught and all_dots asserted in the same cycle in PLAY → state=WON, game_won=1, no Load_L.
- Assert caught during DYING and RESPAWN, and press during PLAY → no state change and no extra pulses.
- Assert Reset_n=0 mid-DYING (counter=2), release, apply ticks → state=IDLE, counter=0, freeze=1, no lifeDown ever emitted.
